data_memory_bw: RTL

Parametrised, byte-addressable data memory for the Antares datapath MEM stage. It serves loads and stores of byte, halfword, word and (when 64 bits wide) doubleword size. Stores use per-byte lane enables; loads return sign- or zero-extended data. Reads are registered with a one-cycle valid/response handshake, and misaligned or out-of-range accesses are flagged instead of corrupting memory.

---
 rtl/data_memory_bw.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_memory_bw.sv
// Byte-addressable data memory for the Antares MEM stage: lane-enabled stores,
// registered loads with sign/zero extension, and misalignment/range error flagging.
module data_memory_bw #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 16384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int unsigned B      = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(B);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [LANE_W-1:0]     lane;
  logic [IDX_W-1:0]      idx;
  logic                  oor, misalign, err, accept, wr_en, rd_en;
  int unsigned           lane_u, nbytes_u;
  logic [B-1:0]          be;
  logic [DATA_WIDTH-1:0] wdata_sh;

  // active_q stays low through the first edge after reset release so that a
  // store presented on that edge is not performed.
  logic                  active_q;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  load_q, load_d;
  logic [LANE_W-1:0]     lane_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] word_q;

  assign lane     = req_addr[LANE_W-1:0];
  assign idx      = req_addr[LANE_W +: IDX_W];
  assign oor      = |(req_addr >> (LANE_W + IDX_W));
  assign lane_u   = 32'(lane);
  assign nbytes_u = 32'd1 << req_size;
  assign wdata_sh = req_wdata << {lane, 3'b000};

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = (DATA_WIDTH == 32) || (|req_addr[2:0]);
      default: misalign = 1'b0;
    endcase
  end

  assign err     = misalign | oor;
  assign accept  = req_valid & active_q;
  assign wr_en   = accept & ~err & req_write;
  assign rd_en   = accept & ~err & ~req_write;
  assign valid_d = accept;
  assign err_d   = accept & err;
  assign load_d  = rd_en;

  always_comb begin
    be = '0;
    for (int unsigned i = 0; i < B; i++) begin
      be[i] = (i >= lane_u) && (i < lane_u + nbytes_u);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < B; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
      lane_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      active_q <= 1'b1;
      valid_q  <= valid_d;
      err_q    <= err_d;
      load_q   <= load_d;
      if (rd_en) begin
        word_q <= mem[idx];
        lane_q <= lane;
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
    end
  end

  logic [DATA_WIDTH-1:0] shifted, mask, ext;
  logic                  sign;
  int unsigned           rbytes_u;

  assign shifted  = word_q >> {lane_q, 3'b000};
  assign rbytes_u = 32'd1 << size_q;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < B; i++) begin
      mask[i*8 +: 8] = (i < rbytes_u) ? 8'hFF : 8'h00;
    end
    case (size_q)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DATA_WIDTH-1];
    endcase
    // A full-width mask leaves ~mask empty, so req_unsigned has no effect there.
    ext = (shifted & mask) | ((!uns_q && sign) ? ~mask : '0);
  end

  assign rsp_valid = valid_q;
  assign rsp_error = err_q;
  assign rsp_rdata = (valid_q && load_q) ? ext : '0;

endmodule
